// File: rtl/uart_tx_feeder.sv
// Byte FIFO and pacing stage in front of a UART transmitter.
// Producers push bytes at full clock rate; the block launches them one at a
// time on the transmitter's DV/Byte/Done handshake, optionally inserts an
// idle gap after each done, and abandons a byte whose done never arrives.
//
// Ports:
//   CLK, RST_N        clock (rising edge) and asynchronous active-low reset
//   i_Wr_En/i_Wr_Byte push one byte per cycle
//   o_Full/o_Empty    FIFO holds DEPTH / 0 bytes (registered)
//   o_Level           current byte count (registered)
//   o_Overflow        sticky: push attempted while full
//   o_Tx_Err          sticky: done timeout occurred
//   i_Err_Clr         clears both sticky flags (a same-cycle set wins)
//   o_Tx_DV/o_Tx_Byte one-cycle launch strobe and byte to the transmitter
//   i_Tx_Done         one-cycle completion strobe from the transmitter
module uart_tx_feeder #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned GAP_TICKS     = 0,
    parameter int unsigned TIMEOUT_TICKS = 2000000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     i_Wr_En,
    input  logic [7:0]               i_Wr_Byte,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Level,
    output logic                     o_Overflow,
    output logic                     o_Tx_Err,
    input  logic                     i_Err_Clr,
    output logic                     o_Tx_DV,
    output logic [7:0]               o_Tx_Byte,
    input  logic                     i_Tx_Done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic [LVL_W-1:0] count_nxt;
    logic             full;
    logic             push;
    logic             pop;
    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // Push/pop qualification and next occupancy.
    always_comb begin
        full      = (count == LVL_W'(DEPTH));
        push      = i_Wr_En && !full;
        pop       = (state == S_IDLE) && (count != '0);
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + LVL_W'(1);
            2'b01:   count_nxt = count - LVL_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Byte storage; contents need no reset since count guards every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    // Pointers, occupancy views and the overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Level    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            o_Level <= count_nxt;
            o_Full  <= (count_nxt == LVL_W'(DEPTH));
            o_Empty <= (count_nxt == '0);
            // A push at full is dropped even if a pop frees a slot this cycle.
            if (i_Wr_En && full) begin
                o_Overflow <= 1'b1;
            end else if (i_Err_Clr) begin
                o_Overflow <= 1'b0;
            end
        end
    end

    // Launch / wait-for-done / gap sequencer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            o_Tx_Err  <= 1'b0;
        end else begin
            o_Tx_DV <= 1'b0;
            // Clear first so a timeout in the same cycle overrides it.
            if (i_Err_Clr) begin
                o_Tx_Err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_Tx_Byte <= mem[rd_ptr];
                        o_Tx_DV   <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        if (GAP_TICKS > 0) begin
                            gap_cnt <= GAP_W'(GAP_TICKS);
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_TICKS)) begin
                        // Byte is abandoned, not retried.
                        o_Tx_Err <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO and pacing stage that sits directly upstream of the UART transmitter instance.
- Any producer (echo logic, frame generator) pushes bytes at full clock rate without watching transmitter state.
- The block buffers the bytes and hands them one at a time to the transmitter through its DV/Byte/Done handshake.
- It can insert an inter-byte gap and recovers from a transmitter that never reports done.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, at least 2.
- GAP_TICKS, 0, idle CLK cycles inserted after each i_Tx_Done before the next byte is launched; 0 means no gap.
- TIMEOUT_TICKS, 2000000, maximum CLK cycles to wait for i_Tx_Done after launch; must be greater than one UART frame time.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- i_Wr_En  in  1  push request, one byte per cycle.
- i_Wr_Byte  in  8  byte to push.
- o_Full  out  1  FIFO holds DEPTH bytes.
- o_Empty  out  1  FIFO holds 0 bytes.
- o_Level  out  $clog2(DEPTH)+1  current byte count.
- o_Overflow  out  1  sticky: a push was attempted while full.
- o_Tx_Err  out  1  sticky: a done timeout occurred.
- i_Err_Clr  in  1  clears o_Overflow and o_Tx_Err.
- o_Tx_DV  out  1  one-cycle launch strobe to the transmitter.
- o_Tx_Byte  out  8  byte presented to the transmitter.
- i_Tx_Done  in  1  one-cycle completion strobe from the transmitter.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO pointers and count go to 0; state goes to IDLE; timers clear.
  - o_Tx_DV=0, o_Tx_Byte=0, o_Overflow=0, o_Tx_Err=0, o_Empty=1, o_Full=0, o_Level=0.
  - Reset asserted mid-transfer discards FIFO contents and any in-flight state; the transmitter finishes its frame on its own, and a done arriving after reset release is ignored in IDLE.
- FIFO:
  - Circular buffer with a write pointer and a read pointer, each wrapping modulo DEPTH.
  - Count is held in a register; o_Full, o_Empty and o_Level are registered views of that count.
  - Push is accepted iff i_Wr_En=1 and count<DEPTH at the clock edge.
  - A push while count==DEPTH is dropped and sets o_Overflow, even if a pop happens in the same cycle.
  - Push and pop in the same cycle while not full: count is unchanged and both pointers advance.
  - A byte pushed into an empty FIFO is poppable on the following edge. There is no fall-through.
- Sticky flags: if a set event and i_Err_Clr occur in the same cycle, the set wins.
- State machine (IDLE, WAIT_DONE, GAP):
  - IDLE: if count>0 at edge k, pop the head into o_Tx_Byte, set o_Tx_DV=1 and move to WAIT_DONE. o_Tx_DV is therefore high for exactly cycle k+1. If count==0, stay in IDLE.
  - WAIT_DONE:
    - o_Tx_DV=0. A timeout counter starts from 0 on entry.
    - On i_Tx_Done=1: go to GAP if GAP_TICKS>0 (loading the gap counter with GAP_TICKS), otherwise go to IDLE.
    - If the counter reaches TIMEOUT_TICKS without a done: set o_Tx_Err and go to IDLE. The byte is lost and is not retried.
  - GAP: decrement the gap counter each cycle; go to IDLE when it reaches 1. Done strobes in GAP are ignored.
- Timing:
  - Minimum spacing between consecutive o_Tx_DV pulses is (transmitter frame time) + 1 + GAP_TICKS cycles after the done.
  - Latency from a push into an empty idle FIFO to o_Tx_DV high is 2 cycles.
- o_Tx_Byte holds its last value between launches. It changes only on a pop.
- Counter widths are sized from TIMEOUT_TICKS and GAP_TICKS; no wrap-around is permitted before the compare.

Test Plan:
- Reset, then push 0x41 at cycle 0 -> o_Tx_DV high only at cycle 2 with o_Tx_Byte=0x41; o_Level goes 0->1->0.
- Push 0x01..0x05 back-to-back; the transmitter model returns done 50 cycles after each DV -> DV pulses carry 0x01..0x05 in order, each following the previous done by 1 cycle (GAP_TICKS=0).
- GAP_TICKS=10, two bytes queued -> second DV rises exactly 11 cycles after the first i_Tx_Done.
- With the transmitter stalled, push 17 bytes into DEPTH=16 -> o_Full=1 after the 16th push; the 17th push sets o_Overflow; o_Level=16. Releasing the transmitter drains the 16 bytes in order and never emits the 17th. i_Err_Clr then clears o_Overflow.
- TIMEOUT_TICKS=100 and done never returned -> o_Tx_Err=1 at cycle 101 after DV; the next queued byte launches on the following cycle.
- Assert RST_N low while 3 bytes are queued and in WAIT_DONE -> all outputs return to reset values immediately; a done after release produces no DV.
